pixel_to_block: RTL and testbench

PIXEL_TO_BLOCK -- requirements
Module: pixel_to_block

---
 rtl/pixel_to_block_if.sv | 23 ++
 rtl/pixel_to_block.sv | 87 ++++++++
 tb/tb_pixel_to_block.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pixel_to_block_if.sv
// pixel_to_block_if: pixel stream and block handshake in, BRAM write port and block status out
interface pixel_to_block_if;
   logic        pixel_valid;
   logic [9:0]  pixel_in;
   logic [7:0]  row_count;
   logic [8:0]  col_count;
   logic [31:0] bram_addr;
   logic [31:0] bram_wrdata;
   logic        bram_en;
   logic [3:0]  bram_we;
   logic        block_ready;
   logic [1:0]  block_index;
   logic        block_ack;
   logic        overrun;
   modport master (
      output pixel_valid, pixel_in, row_count, col_count, block_ack,
      input  bram_addr, bram_wrdata, bram_en, bram_we, block_ready, block_index, overrun
   );
   modport slave (
      input  pixel_valid, pixel_in, row_count, col_count, block_ack,
      output bram_addr, bram_wrdata, bram_en, bram_we, block_ready, block_index, overrun
   );
endinterface

// File: rtl/pixel_to_block.sv
// pixel_to_block: packs a 128x128 window of a QVGA stream into 2048-word BRAM blocks
module pixel_to_block #(
   parameter int WIN_COL0   = 96,
   parameter int WIN_ROW0   = 56,
   parameter int BLOCK_ROWS = 32
) (
   input logic         pclk,
   input logic         reset,
   pixel_to_block_if.slave bus
);
   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] CAPTURE = 1'b1;
   localparam int LAST_ADDR = BLOCK_ROWS * 64 - 1;
   logic [0:0]  r_state;
   logic [7:0]  r_tag;
   logic [7:0]  r_hold;
   logic [1:0]  r_widx;
   logic        w_start, w_cap, w_past, w_win, w_wr, w_done, w_unused;
   logic [8:0]  w_dc;
   logic [7:0]  w_dr;
   logic [7:0]  w_tag;
   logic [7:0]  w_pix;
   logic [10:0] w_addr;
   logic [1:0]  w_widx;
   assign w_start  = bus.pixel_valid && bus.row_count == 8'd0 && bus.col_count == 9'd0;
   assign w_cap    = w_start || r_state == CAPTURE;
   assign w_past   = bus.pixel_valid && int'(bus.row_count) >= WIN_ROW0 + 128;
   assign w_dc     = bus.col_count - 9'(WIN_COL0);
   assign w_dr     = bus.row_count - 8'(WIN_ROW0);
   assign w_win    = bus.pixel_valid && w_cap
                     && int'(bus.col_count) >= WIN_COL0 && int'(bus.col_count) < WIN_COL0 + 128
                     && int'(bus.row_count) >= WIN_ROW0 && int'(bus.row_count) < WIN_ROW0 + 128;
   assign w_wr     = w_win && w_dc[0];
   assign w_tag    = w_start ? r_tag + 8'd1 : r_tag;
   assign w_pix    = {bus.pixel_in[1:0], bus.pixel_in[9:4]};
   assign w_addr   = 11'((int'(w_dr) % BLOCK_ROWS) * 64 + int'(w_dc[8:1]));
   assign w_widx   = 2'(int'(w_dr) / BLOCK_ROWS);
   assign w_done   = bus.bram_en && bus.bram_addr == 32'(LAST_ADDR);
   assign w_unused = ^bus.pixel_in[3:2];
   // frame tracking: (0,0) starts or restarts a capture, leaving the window's rows ends it
   always_ff @(posedge pclk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_tag   <= 8'd0;
      end else begin
         r_tag   <= w_tag;
         r_state <= w_start ? CAPTURE : (w_past ? IDLE : r_state);
      end
   end
   // even pixel waits for its odd partner; consumed by the write or dropped on a new frame
   always_ff @(posedge pclk) begin
      if (!reset) r_hold <= 8'd0;
      else r_hold <= (w_win && !w_dc[0]) ? w_pix : ((w_wr || w_start) ? 8'd0 : r_hold);
   end
   // one registered BRAM write per odd in-window pixel
   always_ff @(posedge pclk) begin
      if (!reset) begin
         bus.bram_en     <= 1'b0;
         bus.bram_we     <= 4'h0;
         bus.bram_addr   <= 32'd0;
         bus.bram_wrdata <= 32'd0;
         r_widx          <= 2'd0;
      end else begin
         bus.bram_en <= w_wr;
         bus.bram_we <= {4{w_wr}};
         if (w_wr) begin
            bus.bram_addr   <= 32'(w_addr);
            bus.bram_wrdata <= {w_tag, r_hold, w_tag, w_pix};
            r_widx          <= w_widx;
         end
      end
   end
   // block status: completion wins over a same-edge ack; an unacked completion is an overrun
   always_ff @(posedge pclk) begin
      if (!reset) begin
         bus.block_ready <= 1'b0;
         bus.block_index <= 2'd0;
         bus.overrun     <= 1'b0;
      end else if (w_done) begin
         bus.block_ready <= 1'b1;
         bus.block_index <= r_widx;
         bus.overrun     <= bus.overrun | (bus.block_ready & ~bus.block_ack);
      end else if (bus.block_ack) begin
         bus.block_ready <= 1'b0;
      end
   end
endmodule

// File: tb/tb_pixel_to_block.sv
// tb_pixel_to_block: random window scans scored against expected BRAM words and block events
module tb_pixel_to_block;
   localparam int C0 = 96, R0 = 56, BR = 32, LAST = BR * 64 - 1;
   logic pclk = 1'b0;
   logic reset = 1'b0;
   pixel_to_block_if bus ();
   pixel_to_block #(.WIN_COL0(C0), .WIN_ROW0(R0), .BLOCK_ROWS(BR)) dut (
      .pclk(pclk), .reset(reset), .bus(bus));
   always #5 pclk = ~pclk;
   int n_chk = 0, n_err = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // reference state: frame tag, capture flag, pending even pixel (-1 = none)
   int m_tag = 0, m_even = -1, n_done = 0;
   bit m_cap = 0, m_ovr = 0, m_pending = 0, ack_mode = 0;
   int q_addr[$], q_data[$], q_blk[$];
   task automatic pix(input int r, input int c, input logic [9:0] v);
      int a, ev, px;
      @(negedge pclk);
      bus.pixel_valid = 1'b1;
      bus.row_count   = 8'(r);
      bus.col_count   = 9'(c);
      bus.pixel_in    = v;
      px = int'({v[1:0], v[9:4]});
      if (r == 0 && c == 0) begin m_tag = (m_tag + 1) % 256; m_cap = 1; m_even = -1; end
      if (r >= R0 + 128) m_cap = 0;
      if (m_cap && c >= C0 && c < C0 + 128 && r >= R0 && r < R0 + 128) begin
         if ((c - C0) % 2 == 0) m_even = px;
         else begin
            a  = ((r - R0) % BR) * 64 + (c - C0) / 2;
            ev = (m_even < 0) ? 0 : m_even;
            q_addr.push_back(a);
            q_data.push_back((m_tag << 24) | (ev << 16) | (m_tag << 8) | px);
            if (a == LAST) q_blk.push_back((r - R0) / BR);
            m_even = -1;
         end
      end
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge pclk);
         bus.pixel_valid = 1'b0;
         bus.row_count   = 8'($urandom);
         bus.col_count   = 9'($urandom);
      end
   endtask
   task automatic frame(input int nrows);
      pix(0, 0, 10'($urandom));
      for (int r = R0; r < R0 + nrows; r++)
         for (int c = C0; c < C0 + 128; c++) begin
            if ($urandom_range(0, 7) == 0) idle(1);
            if ($urandom_range(0, 15) == 0) pix(r, $urandom_range(0, 1) ? C0 - 1 : C0 + 128, 10'($urandom));
            pix(r, c, 10'($urandom));
         end
      if (nrows == 128) pix(R0 + 128, C0, 10'($urandom));
      idle(4);
   endtask
   task automatic check_reset_outputs(input string p);
      check({p, "_addr"}, bus.bram_addr, 0);
      check({p, "_wrdata"}, bus.bram_wrdata, 0);
      check({p, "_en"}, 32'(bus.bram_en), 0);
      check({p, "_we"}, 32'(bus.bram_we), 0);
      check({p, "_ready"}, 32'(bus.block_ready), 0);
      check({p, "_index"}, 32'(bus.block_index), 0);
      check({p, "_overrun"}, 32'(bus.overrun), 0);
   endtask
   // scoreboard: every write must be the next expected word; block status follows one cycle later
   bit pend = 0;
   int pend_idx = 0;
   bit pend_ovr = 0;
   always @(posedge pclk) begin
      #1;
      if (pend) begin
         check("blk_ready", 32'(bus.block_ready), 1);
         check("blk_index", 32'(bus.block_index), pend_idx);
         check("blk_overrun", 32'(bus.overrun), 32'(pend_ovr));
         pend = 0;
      end
      if (bus.bram_en) begin
         if (q_addr.size() == 0) check("spurious_write_en", 32'(bus.bram_en), 0);
         else begin
            int ea, ed;
            ea = q_addr.pop_front();
            ed = q_data.pop_front();
            check("wr_addr", bus.bram_addr, ea);
            check("wr_data", bus.bram_wrdata, ed);
            check("wr_we", 32'(bus.bram_we), 32'hF);
            if (ea == LAST && q_blk.size() > 0) begin
               pend     = 1;
               pend_idx = q_blk.pop_front();
               pend_ovr = m_ovr | m_pending;
               m_ovr    = pend_ovr;
               m_pending = 1;
               n_done++;
            end
         end
      end
   end
   // consumer: in ack mode, pulse block_ack once per block_ready
   initial begin
      bus.block_ack = 1'b0;
      forever begin
         @(posedge pclk); #2;
         if (ack_mode && bus.block_ready) begin
            bus.block_ack = 1'b1;
            m_pending = 0;
            @(posedge pclk); #2;
            bus.block_ack = 1'b0;
            check("ready_after_ack", 32'(bus.block_ready), 0);
         end
      end
   end
   initial begin
      #3_000_000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end
   initial begin
      bus.pixel_valid = 1'b0;
      bus.pixel_in    = 10'd0;
      bus.row_count   = 8'd0;
      bus.col_count   = 9'd0;
      repeat (3) @(posedge pclk);
      #1;
      check_reset_outputs("rst");
      @(negedge pclk);
      reset = 1'b1;
      // first pair of the window
      pix(0, 0, 10'h000);
      pix(R0, C0, 10'h051);
      pix(R0, C0 + 1, 10'h092);
      @(posedge pclk); #1;
      check("pair_en", 32'(bus.bram_en), 1);
      check("pair_addr", bus.bram_addr, 0);
      check("pair_wrdata", bus.bram_wrdata, 32'h0145_0189);
      check("pair_we", 32'(bus.bram_we), 32'hF);
      // odd pixel with no even partner
      pix(R0, C0 + 3, 10'h2C3);
      @(posedge pclk); #1;
      check("lone_addr", bus.bram_addr, 1);
      check("lone_even_half", 32'(bus.bram_wrdata[23:16]), 0);
      check("lone_odd_half", 32'(bus.bram_wrdata[15:0]), 32'h01EC);
      idle(3);
      // full frame with acks, restarting the capture in progress
      ack_mode = 1;
      n_done = 0;
      frame(128);
      check("acked_blocks", n_done, 4);
      check("acked_ready", 32'(bus.block_ready), 0);
      check("acked_overrun", 32'(bus.overrun), 0);
      check("acked_queue", q_addr.size(), 0);
      // window pixels after the window without a frame start produce nothing
      pix(R0, C0, 10'($urandom));
      pix(R0, C0 + 1, 10'($urandom));
      idle(3);
      // full frame never acked
      ack_mode = 0;
      n_done = 0;
      frame(128);
      check("unacked_blocks", n_done, 4);
      check("unacked_ready", 32'(bus.block_ready), 1);
      check("unacked_index", 32'(bus.block_index), 3);
      check("unacked_overrun", 32'(bus.overrun), 1);
      check("unacked_queue", q_addr.size(), 0);
      // reset midway through block 2
      frame(64 + 5);
      @(negedge pclk);
      reset = 1'b0;
      @(posedge pclk); #1;
      check_reset_outputs("midrst");
      m_tag = 0; m_cap = 0; m_even = -1; m_ovr = 0; m_pending = 0;
      q_addr.delete(); q_data.delete(); q_blk.delete();
      @(negedge pclk);
      reset = 1'b1;
      for (int r = R0; r < R0 + 2; r++)
         for (int c = C0; c < C0 + 128; c++) pix(r, c, 10'($urandom));
      idle(3);
      check("no_start_ready", 32'(bus.block_ready), 0);
      pix(0, 0, 10'($urandom));
      pix(R0, C0, 10'($urandom));
      pix(R0, C0 + 1, 10'($urandom));
      @(posedge pclk); #1;
      check("restart_tag_hi", 32'(bus.bram_wrdata[31:24]), 1);
      check("restart_tag_lo", 32'(bus.bram_wrdata[15:8]), 1);
      idle(3);
      check("final_queue", q_addr.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
